// File: rtl/pcs_enc_pkg.sv
// Shared definitions for the multi-word 64b/66b PCS transmit encoder.
// Holds the fixed word/block widths, the block-type and state encodings, the
// control characters, the block-type bytes and the error block, plus the
// per-word transmit state transition function.
package pcs_enc_pkg;

    localparam int unsigned LEN_TX_DATA     = 64;
    localparam int unsigned LEN_TX_CTRL     = 8;
    localparam int unsigned LEN_CODED_BLOCK = 66;
    localparam int unsigned LEN_TYPE        = 3;

    // Reported block type per word.
    typedef enum logic [2:0] {
        TypeC = 3'd0,
        TypeS = 3'd1,
        TypeD = 3'd2,
        TypeT = 3'd3,
        TypeE = 3'd4
    } blk_type_e;

    // Transmit state machine.
    typedef enum logic [2:0] {
        TxInit = 3'd0,
        TxC    = 3'd1,
        TxD    = 3'd2,
        TxT    = 3'd3,
        TxE    = 3'd4
    } tx_state_e;

    // Sync headers, bit 0 goes on the wire first.
    localparam logic [1:0] SyncData = 2'b01;
    localparam logic [1:0] SyncCtrl = 2'b10;

    // Block type bytes.
    localparam logic [7:0] BtCtrl  = 8'h1E;
    localparam logic [7:0] BtStart = 8'h78;
    localparam logic [7:0] BtOset  = 8'h4B;

    // XGMII control characters.
    localparam logic [7:0] CharIdle  = 8'h07;
    localparam logic [7:0] CharError = 8'hFE;
    localparam logic [7:0] CharStart = 8'hFB;
    localparam logic [7:0] CharTerm  = 8'hFD;
    localparam logic [7:0] CharSeq   = 8'h9C;

    // 7-bit control codes inside an all-control block.
    localparam logic [6:0] CodeIdle  = 7'h00;
    localparam logic [6:0] CodeError = 7'h1E;

    localparam logic [LEN_CODED_BLOCK-1:0] EBLOCK = {{8{CodeError}}, BtCtrl, SyncCtrl};

    // Block type byte for a terminate in lane k.
    function automatic logic [7:0] term_type(input logic [2:0] k);
        logic [7:0] bt;
        case (k)
            3'd0:    bt = 8'h87;
            3'd1:    bt = 8'h99;
            3'd2:    bt = 8'hAA;
            3'd3:    bt = 8'hB4;
            3'd4:    bt = 8'hCC;
            3'd5:    bt = 8'hD2;
            3'd6:    bt = 8'hE1;
            default: bt = 8'hFF;
        endcase
        return bt;
    endfunction

    // Destination state for one word; la is the class of the word after it.
    function automatic tx_state_e next_state(input tx_state_e st, input blk_type_e cur,
                                             input blk_type_e la);
        tx_state_e nx;
        nx = TxE;
        case (st)
            TxInit, TxC, TxT: begin
                if (cur == TypeC)      nx = TxC;
                else if (cur == TypeS) nx = TxD;
            end
            TxD: begin
                if (cur == TypeD)                        nx = TxD;
                else if (cur == TypeT && la == TypeC)    nx = TxT;
            end
            TxE: begin
                if (cur == TypeC)                        nx = TxC;
                else if (cur == TypeD)                   nx = TxD;
                else if (cur == TypeT && la == TypeC)    nx = TxT;
            end
            default: nx = TxE;
        endcase
        return nx;
    endfunction

endpackage

// File: rtl/pcs_enc_multiword_sm_if.sv
// Beat bus of the multi-word PCS encoder.
//   i_enable    : beat strobe from the MAC side
//   i_tx_ctrl   : NB_WORDS control masks, word w at [8w+7:8w]
//   i_tx_data   : NB_WORDS data words, word w at [64w+63:64w]
//   o_tx_coded  : NB_WORDS 66-bit coded blocks
//   o_t_type    : NB_WORDS 3-bit block types
//   o_valid     : outputs carry a real beat
//   o_err_count : saturating error block count
// master drives the inputs, slave is the encoder.
interface pcs_enc_multiword_sm_if #(
    parameter int unsigned NB_WORDS    = 2,
    parameter int unsigned LEN_ERR_CNT = 16
);
    logic                                                  i_enable;
    logic [NB_WORDS*pcs_enc_pkg::LEN_TX_CTRL-1:0]          i_tx_ctrl;
    logic [NB_WORDS*pcs_enc_pkg::LEN_TX_DATA-1:0]          i_tx_data;
    logic [NB_WORDS*pcs_enc_pkg::LEN_CODED_BLOCK-1:0]      o_tx_coded;
    logic [NB_WORDS*pcs_enc_pkg::LEN_TYPE-1:0]             o_t_type;
    logic                                                  o_valid;
    logic [LEN_ERR_CNT-1:0]                                o_err_count;

    modport master (
        output i_enable, i_tx_ctrl, i_tx_data,
        input  o_tx_coded, o_t_type, o_valid, o_err_count
    );

    modport slave (
        input  i_enable, i_tx_ctrl, i_tx_data,
        output o_tx_coded, o_t_type, o_valid, o_err_count
    );
endinterface

// File: rtl/pcs_enc_word_classifier.sv
// Combinational classifier for one 64-bit word: decides D/S/T/C/E and builds
// the raw 66-bit block that would be sent if the state machine accepts it.
//   tx_data   : data word, lane j at [8j+7:8j]
//   tx_ctrl   : control mask, bit j set means lane j is a control character
//   raw_block : coded block for the word (EBLOCK when unclassifiable)
//   blk_type  : classified type
module pcs_enc_word_classifier
    import pcs_enc_pkg::*;
(
    input  logic [LEN_TX_DATA-1:0]     tx_data,
    input  logic [LEN_TX_CTRL-1:0]     tx_ctrl,
    output logic [LEN_CODED_BLOCK-1:0] raw_block,
    output blk_type_e                  blk_type
);

    logic        all_ctrl_ok;
    logic [55:0] ctrl_codes;
    logic [7:0]  term_hit;
    logic [7:0]  lane0;

    assign lane0 = tx_data[7:0];

    // All-control block: every lane idle or error, mapped to 7-bit codes.
    always_comb begin
        all_ctrl_ok = 1'b1;
        ctrl_codes  = '0;
        for (int j = 0; j < 8; j++) begin
            if (tx_data[8*j +: 8] == CharIdle) begin
                ctrl_codes[7*j +: 7] = CodeIdle;
            end else if (tx_data[8*j +: 8] == CharError) begin
                ctrl_codes[7*j +: 7] = CodeError;
            end else begin
                all_ctrl_ok = 1'b0;
            end
        end
    end

    // term_hit[k]: terminate in lane k; the ctrl patterns are distinct so at most one hits.
    always_comb begin
        term_hit = '0;
        for (int k = 0; k < 8; k++) begin
            term_hit[k] = (tx_ctrl == (8'hFF << k)) && (tx_data[8*k +: 8] == CharTerm);
            for (int j = k + 1; j < 8; j++) begin
                if (tx_data[8*j +: 8] != CharIdle && tx_data[8*j +: 8] != CharError) begin
                    term_hit[k] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        raw_block = EBLOCK;
        blk_type  = TypeE;
        if (tx_ctrl == 8'h00) begin
            raw_block = {tx_data, SyncData};
            blk_type  = TypeD;
        end else if (tx_ctrl == 8'h01 && lane0 == CharStart) begin
            raw_block = {tx_data[63:8], BtStart, SyncCtrl};
            blk_type  = TypeS;
        end else if (tx_ctrl == 8'h01 && lane0 == CharSeq) begin
            raw_block = {32'h0, tx_data[31:8], BtOset, SyncCtrl};
            blk_type  = TypeC;
        end else if (tx_ctrl == 8'hFF && all_ctrl_ok) begin
            raw_block = {ctrl_codes, BtCtrl, SyncCtrl};
            blk_type  = TypeC;
        end else if (|term_hit) begin
            raw_block = {56'h0, 8'h00, SyncCtrl};
            for (int k = 0; k < 8; k++) begin
                if (term_hit[k]) begin
                    raw_block[9:2] = term_type(3'(k));
                    for (int j = 0; j < k; j++) begin
                        raw_block[10 + 8*j +: 8] = tx_data[8*j +: 8];
                    end
                end
            end
            blk_type = TypeT;
        end
    end

endmodule

// File: rtl/pcs_enc_multiword_sm.sv
// Multi-word 64b/66b PCS transmit encoder, two-stage pipeline.
// Stage 1 registers the per-word classification and raw block. Stage 2 walks
// the transmit state machine across the words in time order and registers the
// coded blocks, the per-word types and a saturating error-block counter.
//   i_clock : clock
//   i_reset : asynchronous active-high reset
//   bus     : beat bus (slave side), see pcs_enc_multiword_sm_if
module pcs_enc_multiword_sm
    import pcs_enc_pkg::*;
#(
    parameter int unsigned NB_WORDS    = 2,
    parameter int unsigned LEN_ERR_CNT = 16
) (
    input logic                   i_clock,
    input logic                   i_reset,
    pcs_enc_multiword_sm_if.slave bus
);

    logic [LEN_CODED_BLOCK-1:0] cls_raw [NB_WORDS];
    blk_type_e                  cls_type [NB_WORDS];

    logic [LEN_CODED_BLOCK-1:0] s1_raw_q [NB_WORDS];
    blk_type_e                  s1_type_q [NB_WORDS];
    logic                       s1_valid_q;

    blk_type_e                  la_type [NB_WORDS];

    tx_state_e                  state_q, state_d;
    tx_state_e                  chain_st, nxt_st;
    logic [NB_WORDS*LEN_CODED_BLOCK-1:0] coded_q, coded_d;
    logic [NB_WORDS*LEN_TYPE-1:0]        type_q, type_d;
    logic                       valid_q;
    logic [LEN_ERR_CNT-1:0]     err_q, err_d;
    logic [LEN_ERR_CNT:0]       err_sum;
    logic [2:0]                 err_n;
    logic                       advance;

    for (genvar w = 0; w < NB_WORDS; w++) begin : g_cls
        pcs_enc_word_classifier u_cls (
            .tx_data   (bus.i_tx_data[LEN_TX_DATA*w +: LEN_TX_DATA]),
            .tx_ctrl   (bus.i_tx_ctrl[LEN_TX_CTRL*w +: LEN_TX_CTRL]),
            .raw_block (cls_raw[w]),
            .blk_type  (cls_type[w])
        );
    end

    // Lookahead: next word of the same beat; the last word peeks at word 0 of
    // the beat entering stage 1, which is valid whenever stage 2 advances.
    for (genvar w = 0; w < NB_WORDS; w++) begin : g_la
        if (w == NB_WORDS - 1) begin : g_last
            assign la_type[w] = cls_type[0];
        end else begin : g_mid
            assign la_type[w] = s1_type_q[w+1];
        end
    end

    // Stage 1.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            s1_valid_q <= 1'b0;
            for (int w = 0; w < NB_WORDS; w++) begin
                s1_raw_q[w]  <= '0;
                s1_type_q[w] <= TypeE;
            end
        end else if (bus.i_enable) begin
            s1_valid_q <= 1'b1;
            for (int w = 0; w < NB_WORDS; w++) begin
                s1_raw_q[w]  <= cls_raw[w];
                s1_type_q[w] <= cls_type[w];
            end
        end
    end

    assign advance = bus.i_enable & s1_valid_q;

    // Stage 2 next-state: words stepped in time order through the state chain.
    always_comb begin
        chain_st = state_q;
        nxt_st   = state_q;
        coded_d  = '0;
        type_d   = '0;
        err_n    = '0;
        for (int w = 0; w < NB_WORDS; w++) begin
            nxt_st = next_state(chain_st, s1_type_q[w], la_type[w]);
            if (nxt_st == TxE) begin
                coded_d[LEN_CODED_BLOCK*w +: LEN_CODED_BLOCK] = EBLOCK;
                type_d[LEN_TYPE*w +: LEN_TYPE]               = TypeE;
                err_n                                        = err_n + 3'd1;
            end else begin
                coded_d[LEN_CODED_BLOCK*w +: LEN_CODED_BLOCK] = s1_raw_q[w];
                type_d[LEN_TYPE*w +: LEN_TYPE]               = s1_type_q[w];
            end
            chain_st = nxt_st;
        end
        state_d = chain_st;
    end

    // Whole-beat sum first, then clamp, so several errors in one beat never wrap.
    assign err_sum = {1'b0, err_q} + {{(LEN_ERR_CNT - 2){1'b0}}, err_n};
    assign err_d   = err_sum[LEN_ERR_CNT] ? '1 : err_sum[LEN_ERR_CNT-1:0];

    // Stage 2 registers.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= TxInit;
            coded_q <= '0;
            type_q  <= {NB_WORDS{LEN_TYPE'(TypeE)}};
            valid_q <= 1'b0;
            err_q   <= '0;
        end else begin
            valid_q <= advance;
            if (advance) begin
                state_q <= state_d;
                coded_q <= coded_d;
                type_q  <= type_d;
                err_q   <= err_d;
            end
        end
    end

    assign bus.o_tx_coded  = coded_q;
    assign bus.o_t_type    = type_q;
    assign bus.o_valid     = valid_q;
    assign bus.o_err_count = err_q;

endmodule

// File: tb/tb_pcs_enc_multiword_sm.sv
// Directed bench for pcs_enc_multiword_sm with NB_WORDS=2: a 16-bit counter
// instance for framing behaviour and a 4-bit counter instance for saturation.
module tb_pcs_enc_multiword_sm;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;

    pcs_enc_multiword_sm_if #(.NB_WORDS(2), .LEN_ERR_CNT(16)) bus ();
    pcs_enc_multiword_sm_if #(.NB_WORDS(2), .LEN_ERR_CNT(4))  bus_s ();

    pcs_enc_multiword_sm #(.NB_WORDS(2), .LEN_ERR_CNT(16)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    pcs_enc_multiword_sm #(.NB_WORDS(2), .LEN_ERR_CNT(4)) dut_s (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus_s)
    );

    // Words and their ctrl masks.
    localparam logic [7:0]  C_C   = 8'hFF;
    localparam logic [63:0] D_C   = 64'h0707070707070707;
    localparam logic [7:0]  C_S   = 8'h01;
    localparam logic [63:0] D_S   = 64'h55555555555555FB;
    localparam logic [7:0]  C_D   = 8'h00;
    localparam logic [63:0] D_D1  = 64'hAAAAAAAAAAAAAAAA;
    localparam logic [63:0] D_D2  = 64'h0123456789ABCDEF;
    localparam logic [63:0] D_D3  = 64'hFEDCBA9876543210;
    localparam logic [7:0]  C_T3  = 8'hF8;
    localparam logic [63:0] D_T3  = 64'h07070707FD111111;
    localparam logic [7:0]  C_T0  = 8'hFF;
    localparam logic [63:0] D_T0  = 64'h07070707070707FD;
    localparam logic [7:0]  C_BAD = 8'h55;

    // Expected coded blocks, hand-built.
    localparam logic [65:0] B_IDLE = 66'h7A;
    localparam logic [65:0] B_S    = {56'h55555555555555, 8'h78, 2'b10};
    localparam logic [65:0] B_D1   = {64'hAAAAAAAAAAAAAAAA, 2'b01};
    localparam logic [65:0] B_D2   = {64'h0123456789ABCDEF, 2'b01};
    localparam logic [65:0] B_D3   = {64'hFEDCBA9876543210, 2'b01};
    localparam logic [65:0] B_T3   = {32'h0, 24'h111111, 8'hB4, 2'b10};
    localparam logic [65:0] B_T0   = 66'h21E;
    localparam logic [65:0] B_E    = {{8{7'h1E}}, 8'h1E, 2'b10};

    logic [3:0] exp_err;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [131:0] obs, input logic [131:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [7:0] c1, input logic [63:0] d1,
                         input logic [7:0] c0, input logic [63:0] d0);
        bus.i_tx_ctrl = {c1, c0};
        bus.i_tx_data = {d1, d0};
    endtask

    initial begin
        bus.i_enable    = 1'b0;
        bus.i_tx_ctrl   = '0;
        bus.i_tx_data   = '0;
        bus_s.i_enable  = 1'b0;
        bus_s.i_tx_ctrl = '0;
        bus_s.i_tx_data = '0;

        // Reset values.
        #1 rst = 1'b1;
        #2;
        chk("rst_coded", bus.o_tx_coded, '0);
        chk("rst_type", bus.o_t_type, 6'o44);
        chk("rst_valid", bus.o_valid, 1'b0);
        chk("rst_err", bus.o_err_count, 16'd0);

        // Idle beats: first output on the third clock.
        drive(C_C, D_C, C_C, D_C);
        bus.i_enable = 1'b1;
        #1 rst = 1'b0;
        step();
        chk("fill_valid", bus.o_valid, 1'b0);
        step();
        chk("idle_coded", bus.o_tx_coded, {B_IDLE, B_IDLE});
        chk("idle_type", bus.o_t_type, {3'd0, 3'd0});
        chk("idle_valid", bus.o_valid, 1'b1);
        chk("idle_err", bus.o_err_count, 16'd0);

        // Frame S|D, T3|C.
        drive(C_D, D_D1, C_S, D_S);
        step();
        drive(C_C, D_C, C_T3, D_T3);
        step();
        chk("sd_coded", bus.o_tx_coded, {B_D1, B_S});
        chk("sd_type", bus.o_t_type, {3'd2, 3'd1});
        drive(C_C, D_C, C_C, D_C);
        step();
        chk("tc_coded", bus.o_tx_coded, {B_IDLE, B_T3});
        chk("tc_type", bus.o_t_type, {3'd0, 3'd3});
        chk("tc_err", bus.o_err_count, 16'd0);

        // T3 followed by D: T becomes EBLOCK, the D recovers to TX_D.
        drive(C_D, D_D1, C_S, D_S);
        step();
        drive(C_D, D_D2, C_T3, D_T3);
        step();
        drive(C_T0, D_T0, C_D, D_D3);
        step();
        chk("td_coded", bus.o_tx_coded, {B_D2, B_E});
        chk("td_type", bus.o_t_type, {3'd2, 3'd4});
        chk("td_err", bus.o_err_count, 16'd1);
        // T0 in the last word uses word 0 of the next beat (C) as lookahead.
        drive(C_C, D_C, C_C, D_C);
        step();
        chk("dt0_coded", bus.o_tx_coded, {B_T0, B_D3});
        chk("dt0_type", bus.o_t_type, {3'd3, 3'd2});
        chk("dt0_err", bus.o_err_count, 16'd1);

        // D while in TX_C, then C recovers.
        drive(C_D, D_D2, C_C, D_C);
        step();
        chk("tc_idle_coded", bus.o_tx_coded, {B_IDLE, B_IDLE});
        drive(C_C, D_C, C_C, D_C);
        step();
        chk("cd_coded", bus.o_tx_coded, {B_E, B_IDLE});
        chk("cd_type", bus.o_t_type, {3'd4, 3'd0});
        chk("cd_err", bus.o_err_count, 16'd2);
        step();
        chk("rec_coded", bus.o_tx_coded, {B_IDLE, B_IDLE});
        chk("rec_type", bus.o_t_type, {3'd0, 3'd0});
        chk("rec_err", bus.o_err_count, 16'd2);

        // Enable gap mid-frame.
        drive(C_D, D_D1, C_S, D_S);
        step();
        drive(C_D, D_D3, C_D, D_D2);
        step();
        chk("pre_gap_coded", bus.o_tx_coded, {B_D1, B_S});
        bus.i_enable = 1'b0;
        drive(C_BAD, 64'h0, C_BAD, 64'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("gap_valid", bus.o_valid, 1'b0);
            chk("gap_coded", bus.o_tx_coded, {B_D1, B_S});
            chk("gap_type", bus.o_t_type, {3'd2, 3'd1});
            chk("gap_err", bus.o_err_count, 16'd2);
        end
        bus.i_enable = 1'b1;
        drive(C_C, D_C, C_T3, D_T3);
        step();
        chk("resume_valid", bus.o_valid, 1'b1);
        chk("resume_coded", bus.o_tx_coded, {B_D3, B_D2});
        chk("resume_type", bus.o_t_type, {3'd2, 3'd2});
        drive(C_C, D_C, C_C, D_C);
        step();
        chk("resume_t_coded", bus.o_tx_coded, {B_IDLE, B_T3});
        chk("resume_t_type", bus.o_t_type, {3'd0, 3'd3});
        chk("resume_err", bus.o_err_count, 16'd2);
        bus.i_enable = 1'b0;

        // Saturation on the 4-bit counter instance: two E words per beat.
        bus_s.i_tx_ctrl = {C_BAD, C_BAD};
        bus_s.i_tx_data = '0;
        bus_s.i_enable  = 1'b1;
        step();
        chk("sat_fill_err", bus_s.o_err_count, 4'd0);
        for (int i = 1; i <= 10; i++) begin
            step();
            exp_err = (2 * i > 15) ? 4'd15 : 4'(2 * i);
            chk("sat_err", bus_s.o_err_count, exp_err);
        end
        chk("sat_coded", bus_s.o_tx_coded, {B_E, B_E});
        chk("sat_type", bus_s.o_t_type, 6'o44);

        // Asynchronous reset between edges.
        #3 rst = 1'b1;
        #1;
        chk("arst_s_err", bus_s.o_err_count, 4'd0);
        chk("arst_s_valid", bus_s.o_valid, 1'b0);
        chk("arst_s_coded", bus_s.o_tx_coded, '0);
        chk("arst_coded", bus.o_tx_coded, '0);
        chk("arst_type", bus.o_t_type, 6'o44);
        chk("arst_err", bus.o_err_count, 16'd0);
        rst = 1'b0;
        bus_s.i_enable = 1'b0;

        // First beats after reset start from TX_INIT.
        bus.i_enable = 1'b1;
        drive(C_D, D_D1, C_S, D_S);
        step();
        chk("post_fill_valid", bus.o_valid, 1'b0);
        drive(C_C, D_C, C_C, D_C);
        step();
        chk("post_coded", bus.o_tx_coded, {B_D1, B_S});
        chk("post_valid", bus.o_valid, 1'b1);
        chk("post_err", bus.o_err_count, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
